mem_port_arbiter: RTL

//   Shares the single external memory port between instruction fetch (cache-miss refills from

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_timeout.sv | 26 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, requester ids, tie-break helper.
package mem_port_arbiter_pkg;

    localparam int DEF_WORD_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS_IF = 2'd1,
        ST_BUS_D  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Data wins when it is the only requester, or on a tie when fetch went last.
    function automatic logic data_wins(input logic if_req, input logic d_req, input owner_t last);
        return d_req && (!if_req || last == OWN_IF);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Cycle counter for the memory-response timeout; expired is high once TIMEOUT-1 is reached.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the external memory port between fetch and data paths,
// one transaction at a time, with per-requester ack/rdata and a response timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int TIMEOUT   = 64,
    parameter int TO_W      = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_ack,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 err,
    output logic                 busy
);

    state_t               state, state_nx;
    owner_t               last_grant;
    logic                 err_flag;
    logic                 lat_we;
    logic [WORD_SIZE-1:0] lat_addr, lat_wdata;
    logic [WORD_SIZE-1:0] if_rdata_q, d_rdata_q;
    logic                 any_req, grant_d, in_bus;
    logic                 to_clear, to_en, to_expired;

    assign any_req = if_req | d_req;
    assign grant_d = data_wins(if_req, d_req, last_grant);
    assign in_bus  = (state == ST_BUS_IF) || (state == ST_BUS_D);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_en),
        .expired (to_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        to_clear = 1'b0;
        to_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx = grant_d ? ST_BUS_D : ST_BUS_IF;
                    to_clear = 1'b1;
                end
            end
            ST_BUS_IF, ST_BUS_D: begin
                if (mem_ready || to_expired)
                    state_nx = ST_DONE;
                else
                    to_en = 1'b1;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // last_grant doubles as the owner of the in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_IF;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            err_flag   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        last_grant <= grant_d ? OWN_D : OWN_IF;
                        lat_we     <= grant_d & d_we;
                        lat_addr   <= grant_d ? d_addr : if_addr;
                        lat_wdata  <= grant_d ? d_wdata : '0;
                        err_flag   <= 1'b0;
                    end
                end
                ST_BUS_IF, ST_BUS_D: begin
                    if (mem_ready) begin
                        if (state == ST_BUS_IF)
                            if_rdata_q <= mem_rdata;
                        else if (!lat_we)
                            d_rdata_q <= mem_rdata;
                    end else if (to_expired) begin
                        err_flag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = in_bus;
    assign mem_we    = in_bus & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_ack    = (state == ST_DONE) && (last_grant == OWN_IF);
    assign d_ack     = (state == ST_DONE) && (last_grant == OWN_D);
    assign err       = (state == ST_DONE) && err_flag;
    assign busy      = (state != ST_IDLE);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
